// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory answering one load/store at a time
// after a fixed LATENCY; byte/half/word access, sign/zero extended loads.
// Ports: clk, reset (sync, active-low); req_valid/req_ready, req_addr,
// req_we, req_size, req_unsigned, req_wdata; rsp_valid/rsp_ready,
// rsp_rdata, rsp_err.
// Option: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word as errors.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Access currently being decoded: live request in IDLE (LATENCY=1
    // commits on the accept edge), captured request otherwise.
    logic [31:0] a_addr, a_wdata;
    logic        a_we, a_uns;
    logic [1:0]  a_size;

    logic [31:0] off;
    logic        acc_err;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword, rword, rshift, ldata;
    logic        commit, mem_we;

    assign req_ready = reset && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_we    = we_q;
        a_uns   = uns_q;
        a_size  = size_q;
        if (state_q == IDLE) begin
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_we    = req_we;
            a_uns   = req_unsigned;
            a_size  = req_size;
        end
    end

    always_comb begin
        off = a_addr - BASE_ADDR;
`ifdef DMEM_MISALIGN_CHECK_EN
        acc_err = ({1'b0, off} >= LIMIT) || (a_size == 2'b11)
                  || ((a_size == 2'b01) && a_addr[0])
                  || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
        acc_err = ({1'b0, off} >= LIMIT) || (a_size == 2'b11);
`endif
        // Misaligned halves/words drop their low address bits here.
        unique case (a_size)
            2'b00:   lane = a_addr[1:0];
            2'b01:   lane = {a_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
        unique case (a_size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        idx    = off[AW+1:2];
        wword  = a_wdata << {lane, 3'b000};
        rword  = mem[idx];
        rshift = rword >> {lane, 3'b000};
        unique case (a_size)
            2'b00:   ldata = a_uns ? {24'h0, rshift[7:0]}
                                   : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ldata = a_uns ? {16'h0, rshift[15:0]}
                                   : {{16{rshift[15]}}, rshift[15:0]};
            default: ldata = rshift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || a_we) ? 32'h0 : ldata;
        end
    end

    // A reset edge must also cancel a commit that would land on it.
    assign mem_we = commit && reset && a_we && !acc_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model,
// randomized and directed loads/stores, backpressure and reset-in-WAIT.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int unsigned LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [DEPTH*4];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          force_hold = 0;
    bit          in_rsp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference: byte-addressed little-endian memory.
    task automatic model(input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        logic [31:0] off;
        logic [31:0] v;
        int a;
        int nb;
        off = addr - BASE;
        err = (size == 2'b11) || (off >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_CHECK_EN
        if (size == 2'b01 && addr[0]) err = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        rd = 32'h0;
        if (!err) begin
            a = int'(off);
            if (size == 2'b01) a = a - (a % 2);
            if (size == 2'b10) a = a - (a % 4);
            nb = 1 << size;
            if (we) begin
                for (int i = 0; i < nb; i++) mb[a+i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[a+i];
                if (size == 2'b00 && !uns && v[7])  v = v | 32'hFFFF_FF00;
                if (size == 2'b01 && !uns && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] wdata, input bit track);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            timeout("req_ready wait");
        end else begin
            req_valid    = 1'b1;
            req_addr     = addr;
            req_we       = we;
            req_size     = size;
            req_unsigned = uns;
            req_wdata    = wdata;
            if (track) begin
                model(addr, we, size, uns, wdata, e.rdata, e.err);
                e.acc = cyc + 1;
                q.push_back(e);
            end
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || in_rsp || rsp_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) timeout("drain");
    endtask

    // Monitor: pops expectations, checks latency, stability and handshake.
    initial begin
        exp_t e;
        logic [31:0] hr;
        logic        he;
        int          hold;
        bit          hs_pend;
        hs_pend   = 0;
        hold      = 0;
        hr        = 32'h0;
        he        = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("req_ready_in_reset", 32'(req_ready), 32'd0);
                in_rsp    = 0;
                hs_pend   = 0;
                rsp_ready = 1'b0;
            end else begin
                if (hs_pend) begin
                    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
                    check("req_ready_after_hs", 32'(req_ready), 32'd1);
                    hs_pend = 0;
                end
                if (rsp_valid) begin
                    if (!in_rsp) begin
                        if (q.size() == 0) begin
                            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                        end else begin
                            e = q.pop_front();
                            check("rdata", rsp_rdata, e.rdata);
                            check("err", 32'(rsp_err), 32'(e.err));
                            check("latency", 32'(cyc + 1 - e.acc), 32'(LAT));
                        end
                        in_rsp = 1;
                        hr     = rsp_rdata;
                        he     = rsp_err;
                        hold   = (force_hold > 0) ? force_hold
                                                  : int'($urandom_range(0, 3));
                    end else begin
                        check("rdata_stable", rsp_rdata, hr);
                        check("err_stable", 32'(rsp_err), 32'(he));
                    end
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (hold > 0) begin
                        rsp_ready = 1'b0;
                        hold--;
                    end else begin
                        rsp_ready = 1'b1;
                        in_rsp    = 0;
                        hs_pend   = 1;
                    end
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Known contents for the region the random phase touches.
        for (int w = 0; w < 16; w++)
            issue(BASE + 32'(4 * w), 1'b1, 2'b10, 1'b0, $urandom, 1);

        issue(32'h0100_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 1);
        issue(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        issue(32'h0100_0013, 1'b1, 2'b00, 1'b0, 32'h0000_0080, 1);
        issue(32'h0100_0013, 1'b0, 2'b00, 1'b0, 32'h0, 1);
        issue(32'h0100_0013, 1'b0, 2'b00, 1'b1, 32'h0, 1);
        issue(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        issue(32'h0100_1000, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        issue(32'h0100_0010, 1'b1, 2'b11, 1'b0, 32'h5555_5555, 1);
        issue(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        issue(32'h0100_0011, 1'b0, 2'b01, 1'b0, 32'h0, 1);
        issue(32'h0100_0012, 1'b0, 2'b01, 1'b1, 32'h0, 1);
        drain();

        force_hold = 5;
        issue(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        drain();
        force_hold = 0;

        // Store lost to a reset landing in WAIT.
        issue(32'h0100_0020, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rsp_valid_reset_wait", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset_wait", 32'(req_ready), 32'd1);
        check("rsp_valid_after_reset_wait", 32'(rsp_valid), 32'd0);
        issue(32'h0100_0020, 1'b0, 2'b10, 1'b0, 32'h0, 1);
        drain();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
                else
                    a = BASE - 32'd1 - 32'($urandom_range(0, 63));
            end else begin
                a = BASE + 32'($urandom_range(0, 63));
            end
            sz = ($urandom_range(0, 7) == 0) ? 2'b11
                                             : 2'($urandom_range(0, 2));
            issue(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  $urandom, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
